// File: rtl/iter_mult_unit.sv
// Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU): retires BITS_PER_CYCLE multiplier bits per clock on magnitudes.
// Optional build macro ITER_MULT_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module iter_mult_unit #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              stall_req
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PW    = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state;
    logic [PW-1:0]             acc;
    logic [PW-1:0]             a_sh;
    logic [DATA_W-1:0]         b_rem;
    logic [CNT_W-1:0]          cnt;
    logic [1:0]                op_q;
    logic                      neg;

    logic                      sign_a;
    logic                      sign_b;
    logic [DATA_W-1:0]         mag_a;
    logic [DATA_W-1:0]         mag_b;
    logic                      launch;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [PW-1:0]             pp;
    logic [PW-1:0]             acc_next;
    logic [PW-1:0]             prod;
    logic [DATA_W-1:0]         b_next;
    logic                      last_step;

    // Operand signs only matter for the signed variants; magnitudes are unsigned,
    // so the most negative value maps cleanly onto 2^(DATA_W-1).
    assign sign_a = ((op == 2'b01) || (op == 2'b10)) && operand_a[DATA_W-1];
    assign sign_b = (op == 2'b01) && operand_b[DATA_W-1];
    assign mag_a  = sign_a ? -operand_a : operand_a;
    assign mag_b  = sign_b ? -operand_b : operand_b;

    assign launch    = start & ~flush & (state != S_RUN);
    assign stall_req = busy | (start & ~flush & ~busy);

    // a_sh already carries the shift position, so one digit is a sum of shifted copies.
    assign digit = b_rem[BITS_PER_CYCLE-1:0];
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (digit[i]) pp = pp + (a_sh << i);
        end
    end

    assign acc_next = acc + pp;
    assign prod     = neg ? -acc_next : acc_next;
    assign b_next   = b_rem >> BITS_PER_CYCLE;

`ifdef ITER_MULT_EARLY_OUT_EN
    assign last_step = (cnt == CNT_W'(1)) || (b_next == '0);
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            a_sh   <= '0;
            b_rem  <= '0;
            cnt    <= '0;
            op_q   <= 2'b00;
            neg    <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (launch) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        a_sh  <= {{DATA_W{1'b0}}, mag_a};
                        b_rem <= mag_b;
                        cnt   <= CNT_W'(N);
                        op_q  <= op;
                        neg   <= sign_a ^ sign_b;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh << BITS_PER_CYCLE;
                    b_rem <= b_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (last_step) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        result <= (op_q == 2'b00) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mult_unit.sv
// Self-checking bench for iter_mult_unit: directed table, multi-cycle corner sequences,
// and random sweeps (64/4 plus 32-bit at 1, 2, 8 bits per cycle) against a sign-extension model.
module tb_iter_mult_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        start, flush;
    logic [1:0]  op;
    logic [63:0] operand_a, operand_b, result;
    logic        busy, done, stall_req;

    logic        s_start, s_flush;
    logic [1:0]  s_op;
    logic [31:0] s_a, s_b;
    logic [31:0] r1, r2, r8;
    logic        b1, b2, b8, d1, d2, d8, q1, q2, q8;

    int tests = 0;
    int fails = 0;

    iter_mult_unit #(.DATA_W(64), .BITS_PER_CYCLE(4)) u_dut (
        .clk(clk), .arst_n(arst_n), .start(start), .flush(flush), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .busy(busy), .done(done), .stall_req(stall_req));

    iter_mult_unit #(.DATA_W(32), .BITS_PER_CYCLE(1)) u_w1 (
        .clk(clk), .arst_n(arst_n), .start(s_start), .flush(s_flush), .op(s_op),
        .operand_a(s_a), .operand_b(s_b), .result(r1), .busy(b1), .done(d1), .stall_req(q1));

    iter_mult_unit #(.DATA_W(32), .BITS_PER_CYCLE(2)) u_w2 (
        .clk(clk), .arst_n(arst_n), .start(s_start), .flush(s_flush), .op(s_op),
        .operand_a(s_a), .operand_b(s_b), .result(r2), .busy(b2), .done(d2), .stall_req(q2));

    iter_mult_unit #(.DATA_W(32), .BITS_PER_CYCLE(8)) u_w8 (
        .clk(clk), .arst_n(arst_n), .start(s_start), .flush(s_flush), .op(s_op),
        .operand_a(s_a), .operand_b(s_b), .result(r8), .busy(b8), .done(d8), .stall_req(q8));

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: extend each operand to 128 bits by the variant's signedness, multiply, pick a half.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ae, be, p;
        logic [63:0]  r;
        logic         sa, sb;
        sa = ((o == 2'b01) || (o == 2'b10)) && a[w-1];
        sb = (o == 2'b01) && b[w-1];
        ae = {128{sa}};
        be = {128{sb}};
        for (int i = 0; i < w; i++) begin
            ae[i] = a[i];
            be[i] = b[i];
        end
        p = ae * be;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (o == 2'b00) ? p[i] : p[i + w];
        return r;
    endfunction

    // Cycle (counted from the start cycle = 0) in which done is expected.
    function automatic int exp_lat(input int w, input int bpc, input logic [1:0] o, input logic [63:0] b);
        logic [63:0] mask, m;
        int bl, k;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        m = b & mask;
        if (o == 2'b01 && b[w-1]) m = (~b + 64'd1) & mask;
        bl = 0;
        for (int i = 0; i < w; i++) if (m[i]) bl = i + 1;
        k = (bl + bpc - 1) / bpc;
        if (k < 1) k = 1;
`ifdef ITER_MULT_EARLY_OUT_EN
        return k + 1;
`else
        return (k > 0) ? (w / bpc + 1) : 0;
`endif
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] v, mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = 64'($urandom_range(0, 20));
            4:       v = mask - 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    // Called right after a posedge (+1); start is held through the next edge.
    task automatic launch64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        #1;
        chk("stall_req on start", stall_req, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output bit sok);
        cyc = c0;
        sok = 1'b1;
        while (!done && cyc < 200) begin
            if (stall_req !== 1'b1 || busy !== 1'b1) sok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic no_done(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk(name, seen, 0);
    endtask

    task automatic run64(input string name, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        int cyc;
        bit sok;
        launch64(o, a, b);
        wait_done(1, cyc, sok);
        chk({name, " done"}, done, 1);
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat(64, 4, o, b)));
        chk({name, " result"}, result, exp);
        chk({name, " stall/busy in run"}, sok, 1);
        chk({name, " stall_req low in DONE"}, stall_req, 0);
        @(posedge clk); #1;
        chk({name, " done one cycle"}, done, 0);
    endtask

    initial begin
        vec_t        vecs[12];
        int          cyc;
        bit          sok;
        logic [63:0] prev, flush_b, ea, eb;
        logic [1:0]  eo;
        int          lat[3];
        logic [31:0] res[3];
        int          elat[3];

        vecs[0]  = '{2'b00, 64'd7, 64'd6, 64'd42};
        vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[2]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
        vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[5]  = '{2'b00, 64'd5, 64'd3, 64'd15};
        vecs[6]  = '{2'b11, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[7]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[8]  = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[9]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{2'b01, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};

        arst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        s_start = 1'b0; s_flush = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset stall_req", stall_req, 0);
        start = 1'b1; #1;
        chk("reset stall_req follows start", stall_req, 1);
        start = 1'b0;
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) run64($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Back-to-back: second launch issued in the DONE cycle
        launch64(2'b00, 64'd7, 64'd6);
        wait_done(1, cyc, sok);
        chk("b2b first done", done, 1);
        chk("b2b first result", result, 42);
        op = 2'b00; operand_a = 64'd3; operand_b = 64'd4; start = 1'b1;
        #1;
        chk("b2b stall_req in DONE with start", stall_req, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b no bubble", busy, 1);
        wait_done(1, cyc, sok);
        chk("b2b second done", done, 1);
        chk("b2b second latency", 64'(cyc), 64'(exp_lat(64, 4, 2'b00, 64'd4)));
        chk("b2b second result", result, 12);
        @(posedge clk); #1;

        // start pulse during RUN is ignored
        launch64(2'b00, 64'd3, 64'h4000_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1;
        op = 2'b01; operand_a = 64'd100; operand_b = 64'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, cyc, sok);
        chk("runstart done", done, 1);
        chk("runstart latency", 64'(cyc), 64'd17);
        chk("runstart result", result, 64'hC000_0000_0000_0000);
        chk("runstart no restart busy", sok, 1);
        no_done("runstart no second done", 25);

        // Flush in cycle 5
`ifdef ITER_MULT_EARLY_OUT_EN
        flush_b = 64'h0500_0000_0000_0005;
`else
        flush_b = 64'd5;
`endif
        prev = result;
        launch64(2'b00, 64'd5, flush_b);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b1;
        #1;
        chk("flush masks stall_req", stall_req, 1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush done", done, 0);
        chk("flush stall_req", stall_req, 0);
        no_done("flush no done pulse", 25);
        chk("flush result kept", result, prev);

        // Reset in cycle 5
        launch64(2'b00, 64'd5, flush_b);
        repeat (4) @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        chk("midreset result", result, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset stall_req", stall_req, 0);
        @(negedge clk); arst_n = 1'b1;
        no_done("midreset no done pulse", 25);

        // Random 64-bit
        for (int n = 0; n < 150; n++) begin
            eo = 2'($urandom_range(0, 3));
            ea = rnd_op(64);
            eb = rnd_op(64);
            run64($sformatf("rnd64 op%0d %h*%h", eo, ea, eb), eo, ea, eb, ref_mul(64, eo, ea, eb));
        end

        // 32-bit sweep over three radices in lockstep
        for (int n = 0; n < 1000; n++) begin
            eo = 2'($urandom_range(0, 3));
            ea = rnd_op(32);
            eb = rnd_op(32);
            s_op = eo; s_a = ea[31:0]; s_b = eb[31:0]; s_start = 1'b1;
            @(posedge clk); #1;
            s_start = 1'b0;
            lat = '{0, 0, 0};
            res = '{32'd0, 32'd0, 32'd0};
            for (int c = 1; c <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); c++) begin
                if (d1 && lat[0] == 0) begin lat[0] = c; res[0] = r1; end
                if (d2 && lat[1] == 0) begin lat[1] = c; res[1] = r2; end
                if (d8 && lat[2] == 0) begin lat[2] = c; res[2] = r8; end
                @(posedge clk); #1;
            end
            elat[0] = exp_lat(32, 1, eo, eb);
            elat[1] = exp_lat(32, 2, eo, eb);
            elat[2] = exp_lat(32, 8, eo, eb);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sweep%0d radix%0d op%0d %h*%h result", n, k, eo, ea[31:0], eb[31:0]),
                    {32'd0, res[k]}, ref_mul(32, eo, ea, eb));
                chk($sformatf("sweep%0d radix%0d latency", n, k), 64'(lat[k]), 64'(elat[k]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
